sequenciador_camadas: RTL
=========================

Name: sequenciador_camadas

Overview:
- Initiator-side controller for the 20-neuron layer unit.
- Time-multiplexes one physical layer across up to MAX_CAMADAS logical layers.
- Drives start, enable, bias, activation-function and input-count controls, and waits for the layer flag.
- Captures the layer outputs and feeds them back as the next layer's inputs, then presents the final vector with a done pulse.

Parameters:
- NUM_NEURO, 20, neurons per physical layer; vector length.
- N, 8, bits per activation value.
- MAX_CAMADAS, 4, maximum logical layers per inference.
- TIMEOUT, 1023, watchdog limit in cycles while waiting for the layer flag.

Ports:
- clk  in  1  system clock.
- iRst_n  in  1  synchronous active-low reset.
- iStart  in  1  one-cycle inference request; ignored while oBusy=1.
- iEntrada  in  NUM_NEURO*N  network input vector; element k at bits [k*N +: N].
- iQtdEntradas  in  5  input count of the first layer.
- iNumCamadas  in  3  number of logical layers, 1..MAX_CAMADAS.
- iQtdNeuros  in  MAX_CAMADAS*5  active neuron count per layer; layer j at [j*5 +: 5].
- iCtrlFA  in  MAX_CAMADAS*2  activation-function select per layer.
- iFlagBias  in  1  bias enable, applied to all layers.
- iR  in  NUM_NEURO*N  layer outputs.
- iFlagCamada  in  1  layer-complete flag.
- oStartNeuro  out  1  neuron start pulse.
- oStartCamada  out  1  layer output enable.
- oEn  out  NUM_NEURO  neuron enables.
- oFlagBias  out  1  registered copy of iFlagBias.
- oCtrlFA  out  2  activation select for the current layer.
- oQtdEntradas  out  5  input count for the current layer.
- oX  out  NUM_NEURO*N  current layer input vector.
- oCamadaIdx  out  3  current layer index; selects weight/bias memory.
- oResultado  out  NUM_NEURO*N  final output vector.
- oDone  out  1  one-cycle completion pulse.
- oBusy  out  1  high from acceptance of iStart until DONE.
- oErro  out  1  sticky error; cleared by the next accepted iStart.

Behaviour:
- All state is registered on the rising edge of clk.
- Reset (iRst_n=0) applies on the next edge regardless of state, including mid-operation:
  - FSM goes to IDLE.
  - Every output is 0: oX, oResultado, oEn, oCamadaIdx, oQtdEntradas, oCtrlFA, oFlagBias, oStartNeuro, oStartCamada, oDone, oBusy, oErro.
- IDLE:
  - On iStart: latch iEntrada into oX, iQtdEntradas into oQtdEntradas, and all per-layer configuration.
  - Clear oErro, set oCamadaIdx=0, set oBusy=1.
  - If iNumCamadas=0 or iNumCamadas>MAX_CAMADAS: set oErro=1 and go to DONE. oResultado is left unchanged.
  - Otherwise go to START.
- START (1 cycle):
  - oStartNeuro=1 and oStartCamada=1.
  - oEn[k]=1 when k<qtd, where qtd=iQtdNeuros[idx] clamped to 1..NUM_NEURO (0 is treated as NUM_NEURO).
  - oCtrlFA is set to the entry for idx.
  - Go to WAIT.
- WAIT:
  - oStartNeuro=0; oStartCamada stays 1.
  - A cycle counter increments each cycle.
  - When iFlagCamada=1, go to CAPTURE.
- CAPTURE (1 cycle):
  - oX[k] is loaded with iR[k] when k<qtd, and with 0 otherwise.
  - oStartCamada drops to 0, which forces the layer flag low before the next layer starts.
  - oQtdEntradas is set to qtd.
- NEXT (1 cycle):
  - If idx=iNumCamadas-1: copy oX into oResultado and go to DONE.
  - Otherwise increment oCamadaIdx and go to START.
- DONE (1 cycle):
  - oDone=1, oBusy=0, oEn=0; go to IDLE.
  - An iStart arriving in the DONE cycle is ignored.
- Latency: for L layers with layer-flag latency Fj, iStart to oDone = 1 + Σ(Fj + 3) + 1 cycles.
- iFlagCamada already high on entry to WAIT is accepted on the first WAIT cycle.
- Control signals that feed the layer are glitch-free because all of them are registered.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- Defined:
  - If the WAIT counter reaches TIMEOUT with iFlagCamada still 0, set oErro=1 and go to DONE.
  - oResultado is unchanged and oStartCamada is dropped.
  - The counter clears on entry to START.
- Undefined: WAIT holds indefinitely; no counter logic is synthesized.

Decomposition:
- Shared package seq_pkg holds:
  - State enum: IDLE, START, WAIT, CAPTURE, NEXT, DONE.
  - Constants NUM_NEURO, N, MAX_CAMADAS, TIMEOUT.
  - Function clamp_qtd.
- One natural sub-module, gerador_enable: a combinational mapping from qtd to the NUM_NEURO-bit thermometer mask, also reused when zeroing unused oX entries.

Test Plan:
- 1 layer with iQtdNeuros[0]=5 and a layer model that raises iFlagCamada 10 cycles after oStartNeuro with iR[k]=k+1 -> oEn=0x0001F, oResultado elements 0..4 = 1..5 and 5..19 = 0, oDone exactly at cycle 1+13+1=15.
- 3 layers with qtd 20, 8, 2 -> oCamadaIdx steps 0, 1, 2; oQtdEntradas for layers 1 and 2 = 20 and 8; oCtrlFA follows per-layer config; a single oDone pulse.
- iNumCamadas=0 -> oErro=1, oDone on cycle 2, and no oStartNeuro pulse.
- iStart pulsed during WAIT and again in DONE -> both ignored; the run completes normally.
- iRst_n=0 during WAIT of layer 2 -> next cycle all outputs are 0 and the FSM is in IDLE; a following iStart runs cleanly from layer 0.
- With SEQ_WATCHDOG_EN, iFlagCamada held at 0 -> oErro=1 and oDone exactly TIMEOUT+1 cycles after entry to WAIT; without the macro, oBusy stays high and no oDone occurs.

Source files
------------

// File: rtl/sequenciador_camadas_pkg.sv
// Shared types and constants for the layer sequencer.
// Optional watchdog is enabled with SEQ_WATCHDOG_EN.
package seq_pkg;

    localparam int NUM_NEURO   = 20;
    localparam int N           = 8;
    localparam int MAX_CAMADAS = 4;
    localparam int TIMEOUT     = 1023;
    localparam int QW          = 5;
    localparam int CW          = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE,
        NEXT,
        DONE
    } estado_t;

    // 0 and anything above NUM_NEURO both mean "all neurons"
    function automatic logic [QW-1:0] clamp_qtd(input logic [QW-1:0] q);
        if (q == '0 || q > QW'(NUM_NEURO)) begin
            return QW'(NUM_NEURO);
        end
        return q;
    endfunction

endpackage

// File: rtl/sequenciador_camadas_gerador_enable.sv
// Thermometer mask: bit k set when k < qtd.
module gerador_enable
    import seq_pkg::*;
(
    input  logic [QW-1:0]        qtd_i,
    output logic [NUM_NEURO-1:0] mask_o
);

    always_comb begin
        mask_o = '0;
        for (int k = 0; k < NUM_NEURO; k++) begin
            mask_o[k] = (QW'(k) < qtd_i);
        end
    end

endmodule

// File: rtl/sequenciador_camadas.sv
// Time-multiplexes one physical neuron layer over several logical layers.
// Define SEQ_WATCHDOG_EN to abort a layer whose flag never arrives.
module sequenciador_camadas
    import seq_pkg::*;
(
    input  logic                          clk,
    input  logic                          iRst_n,
    input  logic                          iStart,
    input  logic [NUM_NEURO*N-1:0]        iEntrada,
    input  logic [QW-1:0]                 iQtdEntradas,
    input  logic [2:0]                    iNumCamadas,
    input  logic [MAX_CAMADAS*QW-1:0]     iQtdNeuros,
    input  logic [MAX_CAMADAS*2-1:0]      iCtrlFA,
    input  logic                          iFlagBias,
    input  logic [NUM_NEURO*N-1:0]        iR,
    input  logic                          iFlagCamada,
    output logic                          oStartNeuro,
    output logic                          oStartCamada,
    output logic [NUM_NEURO-1:0]          oEn,
    output logic                          oFlagBias,
    output logic [1:0]                    oCtrlFA,
    output logic [QW-1:0]                 oQtdEntradas,
    output logic [NUM_NEURO*N-1:0]        oX,
    output logic [2:0]                    oCamadaIdx,
    output logic [NUM_NEURO*N-1:0]        oResultado,
    output logic                          oDone,
    output logic                          oBusy,
    output logic                          oErro
);

    localparam int VW = NUM_NEURO * N;

    estado_t                   state_q;
    logic [VW-1:0]             x_q, res_q, x_cap_d;
    logic [NUM_NEURO-1:0]      en_q, mask_d;
    logic [2:0]                idx_q, idx_nx, nc_q;
    logic [QW-1:0]             qe_q, qtd_q, qtd_d;
    logic [1:0]                fa_q, fa_d;
    logic [MAX_CAMADAS*QW-1:0] qcfg_q;
    logic [MAX_CAMADAS*2-1:0]  facfg_q;
    logic                      sn_q, sc_q, fb_q, done_q, busy_q, erro_q;
    logic                      nc_bad;
`ifdef SEQ_WATCHDOG_EN
    logic [CW-1:0]             wd_q;
`endif

    assign idx_nx = idx_q + 3'd1;
    assign nc_bad = (iNumCamadas == 3'd0) || (iNumCamadas > 3'(MAX_CAMADAS));

    // Config of the layer about to start: live inputs from IDLE, latched copy otherwise
    always_comb begin
        qtd_d = clamp_qtd(qcfg_q[idx_nx*QW +: QW]);
        fa_d  = facfg_q[idx_nx*2 +: 2];
        if (state_q == IDLE) begin
            qtd_d = clamp_qtd(iQtdNeuros[QW-1:0]);
            fa_d  = iCtrlFA[1:0];
        end
    end

    gerador_enable u_en (
        .qtd_i  (qtd_d),
        .mask_o (mask_d)
    );

    always_comb begin
        x_cap_d = '0;
        for (int k = 0; k < NUM_NEURO; k++) begin
            x_cap_d[k*N +: N] = en_q[k] ? iR[k*N +: N] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            res_q   <= '0;
            en_q    <= '0;
            idx_q   <= '0;
            nc_q    <= '0;
            qe_q    <= '0;
            qtd_q   <= '0;
            fa_q    <= '0;
            qcfg_q  <= '0;
            facfg_q <= '0;
            sn_q    <= 1'b0;
            sc_q    <= 1'b0;
            fb_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            erro_q  <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_q    <= '0;
`endif
        end else begin
            fb_q   <= iFlagBias;
            sn_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (iStart) begin
                        x_q     <= iEntrada;
                        qe_q    <= iQtdEntradas;
                        nc_q    <= iNumCamadas;
                        qcfg_q  <= iQtdNeuros;
                        facfg_q <= iCtrlFA;
                        idx_q   <= '0;
                        erro_q  <= nc_bad;
                        busy_q  <= !nc_bad;
                        if (nc_bad) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            sn_q    <= 1'b1;
                            sc_q    <= 1'b1;
                            en_q    <= mask_d;
                            fa_q    <= fa_d;
                            qtd_q   <= qtd_d;
                            state_q <= START;
                        end
                    end
                end
                START: begin
`ifdef SEQ_WATCHDOG_EN
                    wd_q    <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (iFlagCamada) begin
                        sc_q    <= 1'b0;
                        x_q     <= x_cap_d;
                        qe_q    <= qtd_q;
                        state_q <= CAPTURE;
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (wd_q == CW'(TIMEOUT)) begin
                        erro_q  <= 1'b1;
                        sc_q    <= 1'b0;
                        en_q    <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                CAPTURE: begin
                    state_q <= NEXT;
                end
                NEXT: begin
                    if (idx_q == nc_q - 3'd1) begin
                        res_q   <= x_q;
                        en_q    <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_nx;
                        sn_q    <= 1'b1;
                        sc_q    <= 1'b1;
                        en_q    <= mask_d;
                        fa_q    <= fa_d;
                        qtd_q   <= qtd_d;
                        state_q <= START;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oStartNeuro  = sn_q;
    assign oStartCamada = sc_q;
    assign oEn          = en_q;
    assign oFlagBias    = fb_q;
    assign oCtrlFA      = fa_q;
    assign oQtdEntradas = qe_q;
    assign oX           = x_q;
    assign oCamadaIdx   = idx_q;
    assign oResultado   = res_q;
    assign oDone        = done_q;
    assign oBusy        = busy_q;
    assign oErro        = erro_q;

endmodule
